// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction-memory request/ack side, redirect input and
// the valid/ready instruction stream presented to the core.
interface fetch_unit_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic [CW-1:0]   count;

  modport master (
    output mem_req, mem_addr, inst_valid, inst_data, inst_pc, count,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst_data, inst_pc, count,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, keeps one request outstanding to
// instruction memory and buffers {pc, inst} pairs in a small prefetch FIFO.
//
// state  | meaning
// IDLE   | no request outstanding; waits for FIFO space
// FETCH  | request at fetch_pc outstanding, returned word is pushed
// SQUASH | request outstanding across a redirect; returned word is dropped
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, FETCH, SQUASH} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] squash_addr_q;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     data_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_post;
  logic [XLEN-1:0] hold_pc_q;
  logic [31:0]     hold_data_q;
  logic            push, pop;
  logic            unused_bits;

  assign unused_bits = ^bus.redirect_pc[1:0];

  // ack is only meaningful while a request is up; redirect kills both push and pop
  assign push = (state_q == FETCH) && bus.mem_ack && !bus.redirect;
  assign pop  = (count_q != '0) && bus.inst_ready && !bus.redirect;

  always_comb begin
    count_post = count_q;
    if (push && !pop)
      count_post = count_q + CW'(1);
    else if (!push && pop)
      count_post = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect || (count_q < CW'(DEPTH)))
          state_d = FETCH;
      end
      FETCH: begin
        if (bus.redirect)
          state_d = bus.mem_ack ? FETCH : SQUASH;
        else if (bus.mem_ack)
          state_d = (count_post < CW'(DEPTH)) ? FETCH : IDLE;
      end
      SQUASH: begin
        if (bus.mem_ack)
          state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req    = (state_q != IDLE);
    bus.mem_addr   = (state_q == SQUASH) ? squash_addr_q : fetch_pc_q;
    bus.inst_valid = (count_q != '0);
    bus.inst_data  = bus.inst_valid ? data_mem[rd_ptr_q] : hold_data_q;
    bus.inst_pc    = bus.inst_valid ? pc_mem[rd_ptr_q]   : hold_pc_q;
    bus.count      = count_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      squash_addr_q <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hold_pc_q     <= '0;
      hold_data_q   <= '0;
    end else begin
      if (bus.redirect) begin
        fetch_pc_q <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
      end else begin
        if (push) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
          wr_ptr_q   <= wr_ptr_q + AW'(1);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_post;
      end
      // the old address must stay on the bus until the orphaned ack returns
      if ((state_q == FETCH) && bus.redirect && !bus.mem_ack)
        squash_addr_q <= fetch_pc_q;
      if (count_q != '0) begin
        hold_pc_q   <= pc_mem[rd_ptr_q];
        hold_data_q <= data_mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= bus.mem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table covering fill, pop, redirect and
// squash cases, then streaming, async reset and PC wrap-around sequences.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(64), .DEPTH(4)) bus0 ();
  fetch_unit_if #(.XLEN(64), .DEPTH(4)) bus1 ();

  fetch_unit #(.XLEN(64), .DEPTH(4), .RESET_PC(64'h0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.master)
  );
  fetch_unit #(.XLEN(64), .DEPTH(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.master)
  );

  typedef struct {
    logic        redirect;
    logic [63:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic [63:0] rpc, input logic ack,
                     input logic [31:0] rdata, input logic rdy,
                     input logic req, input logic [63:0] addr, input logic vld,
                     input logic [63:0] pc, input logic [31:0] data, input logic [2:0] cnt);
    vec_t v;
    v.redirect = rd;  v.rpc = rpc;   v.ack = ack;     v.rdata = rdata; v.ready = rdy;
    v.e_req = req;    v.e_addr = addr; v.e_valid = vld; v.e_pc = pc;   v.e_data = data;
    v.e_cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // redirect rpc ack rdata ready | req addr valid pc data count
    add(0, 64'h0,   0, 32'h0,         0,  0, 64'h0,   0, 64'h0,   32'h0,         3'd0);
    add(0, 64'h0,   1, 32'hD000_0000, 0,  1, 64'h0,   0, 64'h0,   32'h0,         3'd0);
    add(0, 64'h0,   1, 32'hD000_0001, 0,  1, 64'h4,   1, 64'h0,   32'hD000_0000, 3'd1);
    add(0, 64'h0,   0, 32'h0,         0,  1, 64'h8,   1, 64'h0,   32'hD000_0000, 3'd2);
    add(0, 64'h0,   1, 32'hD000_0002, 0,  1, 64'h8,   1, 64'h0,   32'hD000_0000, 3'd2);
    add(0, 64'h0,   1, 32'hD000_0003, 0,  1, 64'hC,   1, 64'h0,   32'hD000_0000, 3'd3);
    add(0, 64'h0,   1, 32'h0000_0BAD, 1,  0, 64'h10,  1, 64'h0,   32'hD000_0000, 3'd4);
    add(0, 64'h0,   0, 32'h0,         0,  0, 64'h10,  1, 64'h4,   32'hD000_0001, 3'd3);
    add(0, 64'h0,   1, 32'hD000_0004, 1,  1, 64'h10,  1, 64'h4,   32'hD000_0001, 3'd3);
    add(0, 64'h0,   1, 32'hD000_0005, 1,  1, 64'h14,  1, 64'h8,   32'hD000_0002, 3'd3);
    add(1, 64'h203, 0, 32'h0,         1,  1, 64'h18,  1, 64'hC,   32'hD000_0003, 3'd3);
    add(0, 64'h0,   0, 32'h0,         0,  1, 64'h18,  0, 64'hC,   32'hD000_0003, 3'd0);
    add(1, 64'h303, 0, 32'h0,         0,  1, 64'h18,  0, 64'hC,   32'hD000_0003, 3'd0);
    add(0, 64'h0,   1, 32'hDEAD_BEEF, 0,  1, 64'h18,  0, 64'hC,   32'hD000_0003, 3'd0);
    add(0, 64'h0,   1, 32'hE000_0000, 1,  1, 64'h300, 0, 64'hC,   32'hD000_0003, 3'd0);
    add(0, 64'h0,   1, 32'hE000_0001, 0,  1, 64'h304, 1, 64'h300, 32'hE000_0000, 3'd1);
    add(1, 64'h400, 1, 32'hE000_0002, 1,  1, 64'h308, 1, 64'h300, 32'hE000_0000, 3'd2);
    add(0, 64'h0,   0, 32'h0,         0,  1, 64'h400, 0, 64'h300, 32'hE000_0000, 3'd0);
    add(0, 64'h0,   0, 32'h0,         0,  1, 64'h400, 0, 64'h300, 32'hE000_0000, 3'd0);

    reset = 1'b0;
    bus0.mem_ack = 1'b0; bus0.mem_rdata = '0; bus0.redirect = 1'b0;
    bus0.redirect_pc = '0; bus0.inst_ready = 1'b0;
    bus1.mem_ack = 1'b1; bus1.mem_rdata = 32'h1234_5678; bus1.redirect = 1'b0;
    bus1.redirect_pc = '0; bus1.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.inst_data", {32'h0, bus0.inst_data}, 64'h0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      chk($sformatf("v%0d.req", i),   {63'h0, bus0.mem_req},    {63'h0, vecs[i].e_req});
      chk($sformatf("v%0d.addr", i),  bus0.mem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d.valid", i), {63'h0, bus0.inst_valid}, {63'h0, vecs[i].e_valid});
      chk($sformatf("v%0d.pc", i),    bus0.inst_pc,             vecs[i].e_pc);
      chk($sformatf("v%0d.data", i),  {32'h0, bus0.inst_data},  {32'h0, vecs[i].e_data});
      chk($sformatf("v%0d.count", i), {61'h0, bus0.count},      {61'h0, vecs[i].e_cnt});
      if (i == 1) chk("wrap.first", bus1.mem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      if (i == 2) chk("wrap.second", bus1.mem_addr, 64'h0);
      bus0.redirect    = vecs[i].redirect;
      bus0.redirect_pc = vecs[i].rpc;
      bus0.mem_ack     = vecs[i].ack;
      bus0.mem_rdata   = vecs[i].rdata;
      bus0.inst_ready  = vecs[i].ready;
      @(negedge clk);
    end

    // streaming: same-cycle ack, core always ready
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s%0d.addr", k), bus0.mem_addr, 64'h400 + 64'(4 * k));
      chk($sformatf("s%0d.count", k), {61'h0, bus0.count}, (k == 0) ? 64'd0 : 64'd1);
      if (k > 0) begin
        chk($sformatf("s%0d.pc", k), bus0.inst_pc, 64'h400 + 64'(4 * (k - 1)));
        chk($sformatf("s%0d.data", k), {32'h0, bus0.inst_data}, {32'h0, 32'h5000_0000 + 32'(k - 1)});
      end
      bus0.mem_ack    = 1'b1;
      bus0.mem_rdata  = 32'h5000_0000 + 32'(k);
      bus0.inst_ready = 1'b1;
      @(negedge clk);
    end

    // build up to three entries, then reset between edges
    bus0.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("ar.count_before", {61'h0, bus0.count}, 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("ar.count", {61'h0, bus0.count}, 64'd0);
    chk("ar.valid", {63'h0, bus0.inst_valid}, 64'd0);
    chk("ar.req", {63'h0, bus0.mem_req}, 64'd0);
    chk("ar.addr", bus0.mem_addr, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("ar.ack_ignored_count", {61'h0, bus0.count}, 64'd0);
    chk("ar.fetch_req", {63'h0, bus0.mem_req}, 64'd1);
    bus0.mem_ack = 1'b0;
    @(negedge clk);
    chk("ar.still_empty", {63'h0, bus0.inst_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
